// File: rtl/b2bd_iter.sv
// Iterative binary-to-BCD converter (double-dabble, one input bit per clock).
// Optional macro B2BD_SIGNED_EN: two's-complement input, magnitude on led, extra sign output.
module b2bd_iter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      sw,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   led
`ifdef B2BD_SIGNED_EN
  ,
  output logic                  sign
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("b2bd_iter: WIDTH must be in 4..32");
  end
  if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
    $error("b2bd_iter: DIGITS too small to hold 2^WIDTH-1");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] bin_q,   bin_d;
  logic [BW-1:0]    acc_q,   acc_d;
  logic [BW-1:0]    led_q,   led_d;
  logic             done_q,  done_d;
  logic [BW-1:0]    acc_adj;
  logic [WIDTH-1:0] operand;

`ifdef B2BD_SIGNED_EN
  logic neg_q,  neg_d;
  logic sign_q, sign_d;

  // Magnitude stays on WIDTH unsigned bits, so the most negative value maps to 2^(WIDTH-1).
  assign operand = sw[WIDTH-1] ? (~sw + WIDTH'(1)) : sw;
  assign sign    = sign_q;
`else
  assign operand = sw;
`endif

  always_comb begin
    for (int d = 0; d < DIGITS; d++) begin
      acc_adj[4*d +: 4] = (acc_q[4*d +: 4] >= 4'd5) ? acc_q[4*d +: 4] + 4'd3 : acc_q[4*d +: 4];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    led_d   = led_q;
    done_d  = 1'b0;
`ifdef B2BD_SIGNED_EN
    neg_d   = neg_q;
    sign_d  = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = operand;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
`ifdef B2BD_SIGNED_EN
          neg_d   = sw[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        {acc_d, bin_d} = {acc_adj, bin_q} << 1;
        cnt_d          = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIN;
      end
      FIN: begin
        led_d   = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef B2BD_SIGNED_EN
        sign_d  = neg_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
`ifdef B2BD_SIGNED_EN
      neg_q   <= 1'b0;
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      led_q   <= led_d;
      done_q  <= done_d;
`ifdef B2BD_SIGNED_EN
      neg_q   <= neg_d;
      sign_q  <= sign_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign led  = led_q;

endmodule

// File: tb/tb_b2bd_iter.sv
// Scoreboard bench for b2bd_iter: default 8-bit instance plus a 16-bit/5-digit instance.
module tb_b2bd_iter;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start8 = 1'b0;
  logic        start16 = 1'b0;
  logic [7:0]  sw8    = '0;
  logic [15:0] sw16   = '0;
  logic        busy8, done8, busy16, done16;
  logic [11:0] led8;
  logic [19:0] led16;
`ifdef B2BD_SIGNED_EN
  logic        sign8, sign16;
`endif

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int done_cnt8 = 0;
  int done_cnt16 = 0;

  typedef struct {
    logic [31:0] bcd;
    logic        sgn;
    int          accept;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  b2bd_iter #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sw(sw8),
    .busy(busy8), .done(done8), .led(led8)
`ifdef B2BD_SIGNED_EN
    , .sign(sign8)
`endif
  );

  b2bd_iter #(.WIDTH(16), .DIGITS(5)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sw(sw16),
    .busy(busy16), .done(done16), .led(led16)
`ifdef B2BD_SIGNED_EN
    , .sign(sign16)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Integer reference model: decimal digits of the value (or of its magnitude in the signed build).
  function automatic exp_t model(input longint unsigned v, input int width, input int accept);
    exp_t e;
    longint unsigned mag = v;
    e.sgn = 1'b0;
`ifdef B2BD_SIGNED_EN
    if (((v >> (width - 1)) & 64'd1) != 64'd0) begin
      mag   = (64'd1 << width) - v;
      e.sgn = 1'b1;
    end
`endif
    e.bcd = '0;
    for (int i = 0; i < 8; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 64'd10);
      mag = mag / 64'd10;
    end
    e.accept = accept;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done8) begin
      done_cnt8++;
      n_tests++;
      if (q8.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done8: done with led=%h, required no pulse", led8);
      end else begin
        e8 = q8.pop_front();
        if (led8 !== e8.bcd[11:0]) begin
          n_fail++;
          $display("FAIL led8: got %h, required %h", led8, e8.bcd[11:0]);
        end
        n_tests++;
        if (cyc - e8.accept != 9) begin
          n_fail++;
          $display("FAIL latency8: got %0d cycles, required 9", cyc - e8.accept);
        end
`ifdef B2BD_SIGNED_EN
        n_tests++;
        if (sign8 !== e8.sgn) begin
          n_fail++;
          $display("FAIL sign8: got %b, required %b", sign8, e8.sgn);
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done16) begin
      done_cnt16++;
      n_tests++;
      if (q16.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done16: done with led=%h, required no pulse", led16);
      end else begin
        e16 = q16.pop_front();
        if (led16 !== e16.bcd[19:0]) begin
          n_fail++;
          $display("FAIL led16: got %h, required %h", led16, e16.bcd[19:0]);
        end
        n_tests++;
        if (cyc - e16.accept != 17) begin
          n_fail++;
          $display("FAIL latency16: got %0d cycles, required 17", cyc - e16.accept);
        end
`ifdef B2BD_SIGNED_EN
        n_tests++;
        if (sign16 !== e16.sgn) begin
          n_fail++;
          $display("FAIL sign16: got %b, required %b", sign16, e16.sgn);
        end
`endif
      end
    end
  end

  // One-cycle start pulse; the operand is scrambled right after the accepting edge.
  task automatic conv8(input logic [7:0] v);
    @(negedge clk);
    sw8    = v;
    start8 = 1'b1;
    q8.push_back(model(64'(v), 8, cyc + 1));
    @(negedge clk);
    start8 = 1'b0;
    sw8    = ~v;
  endtask

  task automatic conv16(input logic [15:0] v);
    @(negedge clk);
    sw16    = v;
    start16 = 1'b1;
    q16.push_back(model(64'(v), 16, cyc + 1));
    @(negedge clk);
    start16 = 1'b0;
    sw16    = ~v;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((q8.size() != 0 || q16.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_tests++;
    if (q8.size() != 0 || q16.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d/%0d results pending, required 0", q8.size(), q16.size());
      q8.delete();
      q16.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy8, done8, led8} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset8: busy/done/led=%b/%b/%h, required 0/0/000", busy8, done8, led8);
    end
    n_tests++;
    if ({busy16, done16, led16} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset16: busy/done/led=%b/%b/%h, required 0/0/00000", busy16, done16, led16);
    end
`ifdef B2BD_SIGNED_EN
    n_tests++;
    if ({sign8, sign16} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_sign: got %b%b, required 00", sign8, sign16);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0] vals [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
    foreach (vals[i]) begin
      conv8(vals[i]);
      n_tests++;
      if (busy8 !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_after_accept: got %b, required 1", busy8);
      end
      drain(40);
    end
  endtask

  task automatic test_busy_ignore();
    int   base;
    exp_t e;
    e    = model(64'd123, 8, 0);
    base = done_cnt8;
    conv8(8'd123);
    @(negedge clk);
    sw8    = 8'd7;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain(40);
    repeat (12) @(negedge clk);
    n_tests++;
    if (done_cnt8 != base + 1) begin
      n_fail++;
      $display("FAIL ignore_pulses: got %0d done pulses, required 1", done_cnt8 - base);
    end
    n_tests++;
    if (busy8 !== 1'b0 || led8 !== e.bcd[11:0]) begin
      n_fail++;
      $display("FAIL ignore_hold: busy/led=%b/%h, required 0/%h", busy8, led8, e.bcd[11:0]);
    end
  endtask

  task automatic test_back_to_back();
    int a;
    int t = 0;
    int base;
    base = done_cnt8;
    @(negedge clk);
    sw8    = 8'd42;
    start8 = 1'b1;
    a      = cyc + 1;
    q8.push_back(model(64'd42, 8, a));
    q8.push_back(model(64'd17, 8, a + 10));
    @(negedge clk);
    sw8 = 8'd17;
    while (cyc != a + 10 && t < 50) begin
      @(negedge clk);
      t++;
    end
    start8 = 1'b0;
    drain(40);
    n_tests++;
    if (done_cnt8 != base + 2) begin
      n_fail++;
      $display("FAIL held_start_pulses: got %0d done pulses, required 2", done_cnt8 - base);
    end
  endtask

  task automatic test_reset_abort();
    int base;
    conv8(8'd200);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy8, done8, led8} !== 14'd0) begin
      n_fail++;
      $display("FAIL abort_reset: busy/done/led=%b/%b/%h, required 0/0/000", busy8, done8, led8);
    end
    q8.delete();
    base = done_cnt8;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    n_tests++;
    if (done_cnt8 != base || led8 !== 12'h000) begin
      n_fail++;
      $display("FAIL abort_quiet: pulses=%0d led=%h, required 0 and 000", done_cnt8 - base, led8);
    end
    conv8(8'd200);
    drain(40);
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 256; v++) begin
      conv8(8'(v));
      drain(40);
    end
  endtask

  task automatic test_wide();
    logic [15:0] vals [4] = '{16'd65535, 16'd0, 16'd12345, 16'd40960};
    foreach (vals[i]) begin
      conv16(vals[i]);
      drain(60);
    end
  endtask

`ifdef B2BD_SIGNED_EN
  task automatic test_signed();
    logic [7:0]  vals [3] = '{8'h80, 8'hFF, 8'h7F};
    logic [11:0] leds [3] = '{12'h128, 12'h001, 12'h127};
    logic        sgns [3] = '{1'b1, 1'b1, 1'b0};
    foreach (vals[i]) begin
      conv8(vals[i]);
      drain(40);
      n_tests++;
      if (led8 !== leds[i] || sign8 !== sgns[i]) begin
        n_fail++;
        $display("FAIL signed_const: sw=%h got %b/%h, required %b/%h", vals[i], sign8, led8, sgns[i], leds[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_wide();
`ifdef B2BD_SIGNED_EN
    test_signed();
`endif
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/b2bd_iter.md
B2BD_ITER -- requirements
Module: b2bd_iter

Interface
REQ-001 Parameter WIDTH, default 8, binary input width in bits (legal 4..32).
REQ-002 Parameter DIGITS, default 3, BCD output digits; SHALL satisfy 10^DIGITS > 2^WIDTH-1, otherwise elaboration fails.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  conversion request, sampled on rising clk.
REQ-006 sw  input  WIDTH  binary operand, sampled only on the accepting edge.
REQ-007 busy  output  1  high while a conversion is in progress or completing.
REQ-008 done  output  1  single-cycle pulse, result valid.
REQ-009 led  output  4*DIGITS  packed BCD result; digit 0 (ones) in led[3:0].

Function
REQ-010 The block SHALL use the iterative shift-and-add-3 (double-dabble) algorithm, one input bit per clock.
REQ-011 FSM states: IDLE, SHIFT, FIN.
REQ-012 IDLE: when start=1, capture sw into an internal shift register, clear the BCD accumulator, load bit counter = WIDTH, go to SHIFT; otherwise stay.
REQ-013 SHIFT: each cycle, add 3 to every accumulator digit >=5, then shift the {accumulator, operand} left by one bit, and decrement the counter; after the WIDTH-th shift go to FIN.
REQ-014 FIN: copy the accumulator to led, assert done for this cycle only, return to IDLE.
REQ-015 Latency: done SHALL be high in the clock cycle beginning WIDTH+1 edges after the accepting edge; led changes on the same edge that raises done.
REQ-016 busy SHALL equal (state != IDLE).
REQ-017 start while busy=1 SHALL be ignored, with no queuing and no effect on the running conversion.
REQ-018 start held high continuously SHALL start a new conversion on the first edge in IDLE after FIN, giving a throughput of one result per WIDTH+2 cycles.
REQ-019 sw changes after the accepting edge SHALL NOT affect the result.
REQ-020 led SHALL hold the last result between done pulses.
REQ-021 Each led digit SHALL be in 0..9; unused high digits SHALL be zero.
REQ-022 Boundary inputs 0 and 2^WIDTH-1 SHALL convert exactly.

Reset
REQ-023 On rst=1, asynchronously: state=IDLE, busy=0, done=0, led=0, counter=0, internal registers cleared.
REQ-024 rst asserted mid-conversion SHALL abort the conversion; no done pulse SHALL follow and led SHALL read 0.
REQ-025 The first start accepted after rst deasserts SHALL behave as in REQ-012.

Configuration
REQ-026 Macro B2BD_SIGNED_EN: when defined, sw is two's complement, and the block SHALL add an output port sign (1 bit, reset 0, updated with led).
REQ-027 With B2BD_SIGNED_EN, the block SHALL convert |sw| on an unsigned path of WIDTH bits, so that -2^(WIDTH-1) converts to 2^(WIDTH-1), and sign SHALL equal sw[WIDTH-1] as captured.
REQ-028 Without B2BD_SIGNED_EN, sw is unsigned, the sign port SHALL NOT exist, and latency is identical.

Verification (WIDTH=8, DIGITS=3 unless stated)
REQ-029 Unsigned sweep sw=0,9,10,99,100,255 -> led=000,009,010,099,100,255 in BCD (e.g. 255 -> 0010_0101_0101), with done exactly 9 cycles after the accepting edge.
REQ-030 start pulsed at cycle 3 of a conversion with sw=7 -> ignored, the running result is unchanged, and only one done pulse occurs.
REQ-031 start held high with sw=42 then sw=17 -> led=042 then 017, with done pulses 10 cycles apart.
REQ-032 rst asserted 4 cycles into a conversion of sw=200 -> led=0, busy=0, and no done pulse; the next start with sw=200 -> led=200.
REQ-033 With B2BD_SIGNED_EN, sw=8'h80 -> sign=1 and led=128; sw=8'hFF -> sign=1 and led=001; sw=8'h7F -> sign=0 and led=127.
REQ-034 WIDTH=16, DIGITS=5, sw=65535 -> led=6_5535 in BCD with done 17 cycles after the accepting edge; exhaustive compare against an integer model for all 2^8 inputs at the default parameters.
